// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: RV32IM fetch stage. Owns the program counter, issues
// word reads over a busywait handshake, absorbs hazard stalls through a
// one-word skid buffer and applies taken-branch redirects from EX.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    output logic        IMEM_READ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_BUSY,
    input  logic [31:0] IMEM_READDATA,
    output logic [31:0] IF_ID_INSTRUCTION,
    output logic [31:0] IF_ID_PC,
    output logic [31:0] IF_ID_PC4,
    output logic        IF_ID_VALID
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_FETCH,
        S_DRAIN,
        S_HOLD
    } state_t;

    state_t      r_state,  w_state_nxt;
    logic [31:0] r_req_pc, w_req_pc_nxt;
    logic [31:0] r_next_pc, w_next_pc_nxt;
    logic [31:0] r_skid,   w_skid_nxt;
    logic [31:0] r_instr,  w_instr_nxt;
    logic [31:0] r_pc,     w_pc_nxt;
    logic [31:0] r_pc4,    w_pc4_nxt;
    logic        r_valid,  w_valid_nxt;

    logic        w_read;
    logic        w_done;
    logic [31:0] w_target;
    logic [31:0] w_req_pc4;

    assign w_read    = (r_state != S_HOLD);
    assign w_done    = w_read && !IMEM_BUSY;
    assign w_target  = BRANCH_TARGET & ~32'd3;
    assign w_req_pc4 = r_req_pc + 32'd4;

    // Request is suppressed combinationally while reset is asserted.
    assign IMEM_READ         = w_read && RESET;
    assign IMEM_ADDR         = r_req_pc;
    assign IF_ID_INSTRUCTION = r_instr;
    assign IF_ID_PC          = r_pc;
    assign IF_ID_PC4         = r_pc4;
    assign IF_ID_VALID       = r_valid;

    // State register and all datapath registers; async active-low reset.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state   <= S_FETCH;
            r_req_pc  <= RESET_VECTOR;
            r_next_pc <= RESET_VECTOR;
            r_skid    <= NOP;
            r_instr   <= NOP;
            r_pc      <= 32'd0;
            r_pc4     <= 32'd4;
            r_valid   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_req_pc  <= w_req_pc_nxt;
            r_next_pc <= w_next_pc_nxt;
            r_skid    <= w_skid_nxt;
            r_instr   <= w_instr_nxt;
            r_pc      <= w_pc_nxt;
            r_pc4     <= w_pc4_nxt;
            r_valid   <= w_valid_nxt;
        end
    end

    // Next-state and IF/ID update; branch always wins over stall.
    always_comb begin
        w_state_nxt   = r_state;
        w_req_pc_nxt  = r_req_pc;
        w_next_pc_nxt = r_next_pc;
        w_skid_nxt    = r_skid;
        w_instr_nxt   = r_instr;
        w_pc_nxt      = r_pc;
        w_pc4_nxt     = r_pc4;
        w_valid_nxt   = r_valid;

        case (r_state)
            S_FETCH: begin
                if (w_done) begin
                    if (BRANCH_TAKEN) begin
                        w_req_pc_nxt = w_target;
                        w_valid_nxt  = 1'b0;
                        w_instr_nxt  = NOP;
                    end else if (STALL) begin
                        w_skid_nxt  = IMEM_READDATA;
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_instr_nxt  = IMEM_READDATA;
                        w_pc_nxt     = r_req_pc;
                        w_pc4_nxt    = w_req_pc4;
                        w_valid_nxt  = 1'b1;
                        w_req_pc_nxt = w_req_pc4;
                    end
                end else if (BRANCH_TAKEN) begin
                    // Outstanding access must finish at the old address first.
                    w_next_pc_nxt = w_target;
                    w_valid_nxt   = 1'b0;
                    w_instr_nxt   = NOP;
                    w_state_nxt   = S_DRAIN;
                end else if (!STALL) begin
                    w_valid_nxt = 1'b0;
                    w_instr_nxt = NOP;
                end
            end
            S_DRAIN: begin
                w_valid_nxt = 1'b0;
                w_instr_nxt = NOP;
                if (BRANCH_TAKEN) begin
                    w_next_pc_nxt = w_target;
                end
                if (w_done) begin
                    w_req_pc_nxt = BRANCH_TAKEN ? w_target : r_next_pc;
                    w_state_nxt  = S_FETCH;
                end
            end
            S_HOLD: begin
                if (BRANCH_TAKEN) begin
                    w_req_pc_nxt = w_target;
                    w_valid_nxt  = 1'b0;
                    w_instr_nxt  = NOP;
                    w_state_nxt  = S_FETCH;
                end else if (!STALL) begin
                    // Skid word belongs to r_req_pc; it is never refetched.
                    w_instr_nxt  = r_skid;
                    w_pc_nxt     = r_req_pc;
                    w_pc4_nxt    = w_req_pc4;
                    w_valid_nxt  = 1'b1;
                    w_req_pc_nxt = w_req_pc4;
                    w_state_nxt  = S_FETCH;
                end
            end
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: scoreboard bench for the fetch stage. Expected
// IF/ID words are queued as stimulus is applied and popped whenever IF/ID
// advances with a valid instruction.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        br;
    logic [31:0] br_tgt;
    logic        imem_read;
    logic [31:0] imem_addr;
    logic        imem_busy;
    logic [31:0] imem_data;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;

    logic        w_rst;
    logic        w_read;
    logic [31:0] w_addr;
    logic        w_busy;
    logic [31:0] w_data;
    logic [31:0] w_instr;
    logic [31:0] w_pc;
    logic [31:0] w_pc4;
    logic        w_valid;
    logic        zero1;
    logic [31:0] zero32;

    int unsigned wait_n;
    int unsigned w_wait;
    int unsigned busy_cnt;
    int unsigned w_cnt;
    logic [31:0] salt;

    int n_total;
    int n_bad;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t sb[$];

    instruction_fetch_unit #(.RESET_VECTOR(32'h0000_0000)) u_dut (
        .CLK(clk), .RESET(rst_n), .STALL(stall), .BRANCH_TAKEN(br),
        .BRANCH_TARGET(br_tgt), .IMEM_READ(imem_read), .IMEM_ADDR(imem_addr),
        .IMEM_BUSY(imem_busy), .IMEM_READDATA(imem_data),
        .IF_ID_INSTRUCTION(ifid_instr), .IF_ID_PC(ifid_pc),
        .IF_ID_PC4(ifid_pc4), .IF_ID_VALID(ifid_valid)
    );

    instruction_fetch_unit #(.RESET_VECTOR(32'hFFFF_FFF8)) u_wrap (
        .CLK(clk), .RESET(w_rst), .STALL(zero1), .BRANCH_TAKEN(zero1),
        .BRANCH_TARGET(zero32), .IMEM_READ(w_read), .IMEM_ADDR(w_addr),
        .IMEM_BUSY(w_busy), .IMEM_READDATA(w_data),
        .IF_ID_INSTRUCTION(w_instr), .IF_ID_PC(w_pc),
        .IF_ID_PC4(w_pc4), .IF_ID_VALID(w_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory models: data is a function of the address, busy for wait_n cycles.
    assign imem_data = imem_addr ^ 32'hA5A5_0000 ^ salt;
    assign imem_busy = imem_read && (busy_cnt < wait_n);
    assign w_data    = w_addr ^ 32'hA5A5_0000;
    assign w_busy    = w_read && (w_cnt < w_wait);

    always @(posedge clk) begin
        if (!imem_read || !imem_busy) busy_cnt <= 0;
        else                          busy_cnt <= busy_cnt + 1;
        if (!w_read || !w_busy) w_cnt <= 0;
        else                    w_cnt <= w_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] s);
        exp_t e;
        e.pc    = pc;
        e.instr = pc ^ 32'hA5A5_0000 ^ s;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // IF/ID advanced with a real instruction whenever VALID is high after an
    // edge that saw no stall.
    always @(posedge clk) begin
        logic s_stall;
        logic s_rst;
        exp_t e;
        s_stall = stall;
        s_rst   = rst_n;
        #1;
        if (s_rst && rst_n && ifid_valid && !s_stall) begin
            if (sb.size() == 0) begin
                chk("sb_extra_valid", {31'b0, ifid_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_pc", ifid_pc, e.pc);
                chk("sb_instr", ifid_instr, e.instr);
                chk("sb_pc4", ifid_pc4, e.pc + 32'd4);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_total = 0; n_bad = 0;
        rst_n = 1'b0; w_rst = 1'b0; stall = 1'b0; br = 1'b0; br_tgt = '0;
        wait_n = 0; w_wait = 0; salt = '0; zero1 = 1'b0; zero32 = '0;
        tick(); tick();

        // Reset values
        chk("rst_read", {31'b0, imem_read}, 32'd0);
        chk("rst_instr", ifid_instr, 32'h0000_0013);
        chk("rst_pc", ifid_pc, 32'd0);
        chk("rst_pc4", ifid_pc4, 32'd4);
        chk("rst_valid", {31'b0, ifid_valid}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);

        // Zero-wait streaming
        push(32'h0, 0); push(32'h4, 0); push(32'h8, 0); push(32'hC, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("stream_sb_empty", sb.size(), 0);
        chk("stream_addr", imem_addr, 32'h10);
        rst_n = 1'b0;
        tick();

        // Busy memory, three busy cycles per access
        wait_n = 3;
        tick();
        push(32'h0, 0); push(32'h4, 0); push(32'h8, 0);
        rst_n = 1'b1;
        for (int unsigned i = 1; i <= 12; i++) begin
            logic expv;
            tick();
            expv = (i % 4 == 0);
            chk("busy_addr", imem_addr, 32'(4 * (i / 4)));
            chk("busy_valid", {31'b0, ifid_valid}, {31'b0, expv});
            if (!expv) chk("busy_nop", ifid_instr, 32'h0000_0013);
        end
        chk("busy_sb_empty", sb.size(), 0);
        rst_n = 1'b0;
        tick();

        // Branch while busy at REQ_PC=8
        push(32'h0, 0); push(32'h4, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("brb_addr_pre", imem_addr, 32'h8);
        br = 1'b1; br_tgt = 32'h0000_0103;
        tick();
        br = 1'b0; br_tgt = '0;
        chk("brb_drain_read", {31'b0, imem_read}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("brb_drain_addr", imem_addr, 32'h8);
            chk("brb_drain_valid", {31'b0, ifid_valid}, 32'd0);
            tick();
        end
        chk("brb_target_addr", imem_addr, 32'h100);
        chk("brb_target_valid", {31'b0, ifid_valid}, 32'd0);
        push(32'h100, 0);
        for (int i = 0; i < 4; i++) tick();
        chk("brb_sb_empty", sb.size(), 0);
        chk("brb_addr_next", imem_addr, 32'h104);
        rst_n = 1'b0;
        wait_n = 0;
        tick();

        // Stall on completion of 0x10; memory contents change during HOLD
        push(32'h0, 0); push(32'h4, 0); push(32'h8, 0); push(32'hC, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("stl_addr", imem_addr, 32'h10);
        stall = 1'b1;
        tick();
        salt = 32'h0000_5A5A;
        chk("stl_hold_read", {31'b0, imem_read}, 32'd0);
        chk("stl_hold_pc", ifid_pc, 32'hC);
        tick();
        chk("stl_hold_read2", {31'b0, imem_read}, 32'd0);
        chk("stl_hold_pc2", ifid_pc, 32'hC);
        chk("stl_hold_instr", ifid_instr, 32'hA5A5_000C);
        stall = 1'b0;
        push(32'h10, 0);
        tick();
        chk("stl_release_addr", imem_addr, 32'h14);
        chk("stl_release_read", {31'b0, imem_read}, 32'd1);
        rst_n = 1'b0;
        salt = '0;
        tick();
        chk("stl_sb_empty", sb.size(), 0);

        // Branch and stall together in HOLD
        push(32'h0, 0);
        rst_n = 1'b1;
        tick();
        stall = 1'b1;
        tick();
        chk("bs_hold_read", {31'b0, imem_read}, 32'd0);
        br = 1'b1; br_tgt = 32'h0000_0040;
        tick();
        br = 1'b0; stall = 1'b0; br_tgt = '0;
        chk("bs_valid", {31'b0, ifid_valid}, 32'd0);
        chk("bs_nop", ifid_instr, 32'h0000_0013);
        chk("bs_addr", imem_addr, 32'h40);
        chk("bs_read", {31'b0, imem_read}, 32'd1);
        push(32'h40, 0);
        tick();
        chk("bs_sb_empty", sb.size(), 0);
        rst_n = 1'b0;
        tick();

        // PC wrap and mid-access reset on the second instance
        chk("wrp_rst_read", {31'b0, w_read}, 32'd0);
        w_rst = 1'b1;
        chk("wrp_addr0", w_addr, 32'hFFFF_FFF8);
        tick();
        chk("wrp_pc0", w_pc, 32'hFFFF_FFF8);
        chk("wrp_instr0", w_instr, 32'h5A5A_FFF8);
        chk("wrp_valid0", {31'b0, w_valid}, 32'd1);
        chk("wrp_addr1", w_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrp_pc1", w_pc, 32'hFFFF_FFFC);
        chk("wrp_pc4_1", w_pc4, 32'h0);
        chk("wrp_addr2", w_addr, 32'h0);
        tick();
        chk("wrp_pc2", w_pc, 32'h0);
        chk("wrp_instr2", w_instr, 32'hA5A5_0000);
        chk("wrp_addr3", w_addr, 32'h4);
        w_wait = 3;
        tick();
        chk("wrp_busy_valid", {31'b0, w_valid}, 32'd0);
        chk("wrp_busy_read", {31'b0, w_read}, 32'd1);
        #3;
        w_rst = 1'b0;
        #1;
        chk("mrst_read", {31'b0, w_read}, 32'd0);
        chk("mrst_instr", w_instr, 32'h0000_0013);
        chk("mrst_pc", w_pc, 32'd0);
        chk("mrst_pc4", w_pc4, 32'd4);
        chk("mrst_valid", {31'b0, w_valid}, 32'd0);
        chk("mrst_addr", w_addr, 32'hFFFF_FFF8);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

- Fetch stage of the RV32IM pipeline.
- Owns the program counter and issues word reads to the instruction memory/cache over a busywait handshake.
- Absorbs stalls from the hazard unit and taken-branch redirects from EX.
- Drives the IF/ID pipeline register; decode (including the immediate generator fed from `IF_ID_INSTRUCTION[31:7]`) consumes it.

## Interface
Parameters:
- `RESET_VECTOR`, default `32'h0000_0000`: PC after reset (word aligned).

Ports:
- `CLK` in 1: clock; all state updates on the rising edge.
- `RESET` in 1: asynchronous, active-low reset.
- `STALL` in 1: hazard-unit hold; IF/ID and PC freeze.
- `BRANCH_TAKEN` in 1: redirect request from EX, sampled each edge.
- `BRANCH_TARGET` in 32: redirect address; bits [1:0] forced to 0 internally.
- `IMEM_READ` out 1: read request.
- `IMEM_ADDR` out 32: byte address of the word requested.
- `IMEM_BUSY` in 1: high while the access is incomplete.
- `IMEM_READDATA` in 32: instruction; valid in any cycle with `IMEM_READ=1` and `IMEM_BUSY=0`.
- `IF_ID_INSTRUCTION` out 32: registered instruction; NOP `32'h0000_0013` when not valid.
- `IF_ID_PC` out 32: registered PC of that instruction.
- `IF_ID_PC4` out 32: registered `IF_ID_PC + 4`.
- `IF_ID_VALID` out 1: IF/ID holds a real instruction.

## Operation
- Internal registers:
  - `REQ_PC`: drives `IMEM_ADDR`.
  - `NEXT_PC`: pending redirect target.
  - Skid buffer: one instruction.
  - FSM states: FETCH, DRAIN, HOLD.
- **Completion**: an edge with `IMEM_READ=1` and `IMEM_BUSY=0`.
- **Address stability**: `REQ_PC` changes only on completion or in HOLD, so `IMEM_ADDR` is stable while busy.
- **Priority**: `BRANCH_TAKEN` beats `STALL` in every state.
- **FETCH** (`IMEM_READ=1`):
  - Completion with branch: discard data; `REQ_PC`←target; VALID←0; stay in FETCH.
  - Completion with stall: skid←data; IF/ID unchanged; go to HOLD.
  - Completion otherwise: IF/ID←{data, `REQ_PC`, `REQ_PC+4`, 1}; `REQ_PC`←`REQ_PC+4`.
  - Busy with branch: `NEXT_PC`←target; VALID←0; go to DRAIN.
  - Busy with stall: IF/ID held.
  - Busy otherwise: bubble, VALID←0 and instruction←NOP; PC/PC4 hold.
- **DRAIN** (`IMEM_READ=1`, stale address kept):
  - A further branch overwrites `NEXT_PC`.
  - On completion: data discarded; `REQ_PC`←`NEXT_PC`, or the current target if `BRANCH_TAKEN` is also high that edge; go to FETCH.
  - VALID stays 0 throughout.
- **HOLD** (`IMEM_READ=0`):
  - Branch: skid dropped; `REQ_PC`←target; VALID←0; go to FETCH.
  - `STALL` low: IF/ID←skid with `REQ_PC`/`REQ_PC+4`, VALID=1; `REQ_PC`←`REQ_PC+4`; go to FETCH.
  - Otherwise hold.
- **Arithmetic**: PC arithmetic is 32-bit modulo; `32'hFFFF_FFFC + 4` wraps to 0.
- **Flush**: whenever VALID←0, instruction←NOP.

## Timing
- **Reset** (asynchronous, `RESET` low):
  - `REQ_PC`=`RESET_VECTOR`; state FETCH; skid empty.
  - `IF_ID_INSTRUCTION`=`32'h0000_0013`, `IF_ID_PC`=0, `IF_ID_PC4`=4, `IF_ID_VALID`=0.
  - `IMEM_READ` is forced 0 while `RESET` is low.
  - Reset mid-access abandons the access; the memory must accept a dropped request.
- **Zero-wait memory**:
  - First IF/ID valid at the first rising edge after `RESET` deasserts.
  - Throughput of one instruction per cycle.
- **N busy cycles**: data reaches IF/ID on the edge ending the (N+1)th cycle of the request.
- **Branch penalty**: the redirect takes effect at the sampling edge; the target request is issued the following cycle, or after DRAIN completes.
- **STALL from HOLD**: release restarts fetch with zero refetch of the buffered word.

## Test plan
- **Reset and streaming**: reset, zero-wait memory returning `addr^32'hA5A5_0000`, `RESET_VECTOR=0`.
  - Required: `IF_ID_PC` = 0, 4, 8, 12 on consecutive edges with VALID=1.
  - Required: `IMEM_READ=0` while `RESET` is low.
- **Busy memory**: `IMEM_BUSY` high 3 cycles per access.
  - Required: `IMEM_ADDR` stable during busy; IF/ID shows NOP bubbles with VALID=0 between instructions.
  - Required: a new instruction every 4 cycles.
- **Branch during busy**: at `REQ_PC=8`, assert `BRANCH_TAKEN` with target `32'h0000_0103`.
  - Required: DRAIN keeps `IMEM_ADDR=8` until not busy; its data never appears.
  - Required: next request address `32'h0000_0100`.
- **Stall on completion**: `STALL` high 2 cycles starting at completion of PC 0x10.
  - Required: HOLD with `IMEM_READ=0`, IF/ID frozen.
  - Required: on release, IF/ID shows PC 0x10 with the skid word; no second read of 0x10.
- **Branch and stall together**: `BRANCH_TAKEN` with target `0x40` and `STALL` both high in HOLD.
  - Required: skid dropped, VALID=0, next `IMEM_ADDR=0x40`.
- **Wrap and mid-access reset**: start at `RESET_VECTOR=32'hFFFF_FFF8`.
  - Required: addresses FFF8, FFFC, then 0.
  - Required: `RESET` pulsed low mid-busy returns all outputs to reset values immediately.
